// File: rtl/jogo_sequencia_param_if.sv
// Board-side signal bundle of the memory-sequence game core: player/load inputs,
// result flags, LED vector and debug taps.
interface jogo_sequencia_param_if #(
  parameter int N_CHAVES  = 4,
  parameter int N_JOGADAS = 16
);
  localparam int A = $clog2(N_JOGADAS);

  // No valid/ready pair here: carga is a one-cycle write strobe sampled on the
  // rising edge with no back-pressure; writes outside INICIAL/FIM_* are dropped.
  logic                iniciar;
  logic [N_CHAVES-1:0] chaves;
  logic                carga;
  logic [A-1:0]        end_carga;
  logic [N_CHAVES-1:0] dado_carga;

  logic                acertou;
  logic                errou;
  logic                timeout;
  logic                pronto;
  logic [N_CHAVES-1:0] leds;
  logic [3:0]          db_estado;
  logic [A-1:0]        db_rodada;
  logic [A-1:0]        db_contagem;
  logic [N_CHAVES-1:0] db_jogada;

  modport master (
    output iniciar, chaves, carga, end_carga, dado_carga,
    input  acertou, errou, timeout, pronto, leds,
           db_estado, db_rodada, db_contagem, db_jogada
  );

  modport slave (
    input  iniciar, chaves, carga, end_carga, dado_carga,
    output acertou, errou, timeout, pronto, leds,
           db_estado, db_rodada, db_contagem, db_jogada
  );
endinterface

// File: rtl/jogo_sequencia_param.sv
// Memory-sequence game core: round r asks the player to repeat entries 0..r.
// Define MOSTRA_JOGADA_EN to show mem[rodada] on the LEDs for MOSTRA_CICLOS clocks per round.
module jogo_sequencia_param #(
  parameter int N_CHAVES       = 4,
  parameter int N_JOGADAS      = 16,
  parameter int TIMEOUT_CICLOS = 3000,
  parameter int MOSTRA_CICLOS  = 500
) (
  input logic                   clock,
  input logic                   reset,
  jogo_sequencia_param_if.slave bus
);
  localparam int A  = $clog2(N_JOGADAS);
  localparam int TW = $clog2((TIMEOUT_CICLOS > MOSTRA_CICLOS) ? TIMEOUT_CICLOS : MOSTRA_CICLOS) + 1;
  localparam logic [A-1:0]  ULTIMA = A'(N_JOGADAS - 1);
  localparam logic [A:0]    PROF   = (A+1)'(N_JOGADAS);
  localparam logic [A-1:0]  UM_A   = 1;
  localparam logic [TW-1:0] UM_T   = 1;
  localparam logic [TW-1:0] T_LIM  = TW'(TIMEOUT_CICLOS - 1);
`ifdef MOSTRA_JOGADA_EN
  localparam logic [TW-1:0] M_LIM  = TW'(MOSTRA_CICLOS - 1);
`endif

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    NOVA_RODADA = 4'd2,
    ESPERA      = 4'd3,
    REGISTRA    = 4'd4,
    COMPARA     = 4'd5,
    PROXIMA     = 4'd6,
    FIM_ACERTO  = 4'd7,
    FIM_ERRO    = 4'd8,
    FIM_TIMEOUT = 4'd9
  } estado_t;

  estado_t             r_estado, w_prox;
  logic [A-1:0]        r_rodada, r_contagem;
  logic [TW-1:0]       r_timer;
  logic [N_CHAVES-1:0] r_amostra, r_amostra_ant, r_jogada;
  logic [N_CHAVES-1:0] r_mem [N_JOGADAS];

  logic w_jogada, w_igual, w_carga_ok, w_final;
  logic w_clr_rodada, w_inc_rodada, w_clr_cont, w_inc_cont;
  logic w_inc_timer, w_captura, w_limpa_jogada;
`ifdef MOSTRA_JOGADA_EN
  logic w_rearma;
`endif

  assign w_jogada   = (r_amostra != '0) && (r_amostra_ant == '0);
  assign w_igual    = (r_jogada == r_mem[r_contagem]);
  assign w_final    = r_estado inside {FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT};
  assign w_carga_ok = bus.carga && (w_final || (r_estado == INICIAL)) &&
                      ({1'b0, bus.end_carga} < PROF);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= INICIAL;
    else       r_estado <= w_prox;
  end

  always_comb begin
    w_prox         = r_estado;
    w_clr_rodada   = 1'b0;
    w_inc_rodada   = 1'b0;
    w_clr_cont     = 1'b0;
    w_inc_cont     = 1'b0;
    w_inc_timer    = 1'b0;
    w_captura      = 1'b0;
    w_limpa_jogada = 1'b0;
`ifdef MOSTRA_JOGADA_EN
    w_rearma       = 1'b0;
`endif
    case (r_estado)
      INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (bus.iniciar) begin
          w_prox         = PREPARA;
          w_clr_rodada   = 1'b1;
          w_clr_cont     = 1'b1;
          w_limpa_jogada = 1'b1;
        end
      end
      PREPARA: w_prox = NOVA_RODADA;
      NOVA_RODADA: begin
        w_clr_cont = 1'b1;
`ifdef MOSTRA_JOGADA_EN
        if (r_timer == M_LIM) begin
          w_prox   = ESPERA;
          w_rearma = 1'b1;
        end else begin
          w_inc_timer = 1'b1;
        end
`else
        w_prox = ESPERA;
`endif
      end
      ESPERA: begin
        if (w_jogada)              w_prox = REGISTRA;
        else if (r_timer == T_LIM) w_prox = FIM_TIMEOUT;
        else                       w_inc_timer = 1'b1;
      end
      REGISTRA: begin
        w_captura = 1'b1;
        w_prox    = COMPARA;
      end
      COMPARA: begin
        if (!w_igual)                     w_prox = FIM_ERRO;
        else if (r_contagem != r_rodada)  w_prox = PROXIMA;
        else if (r_rodada == ULTIMA)      w_prox = FIM_ACERTO;
        else begin
          w_inc_rodada = 1'b1;
          w_prox       = NOVA_RODADA;
        end
      end
      PROXIMA: begin
        w_inc_cont = 1'b1;
        w_prox     = ESPERA;
      end
      default: w_prox = INICIAL;
    endcase
  end

  // Timer restarts on every state change; only ESPERA and the show phase count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rodada   <= '0;
      r_contagem <= '0;
      r_timer    <= '0;
      r_jogada   <= '0;
    end else begin
      if (w_clr_rodada)      r_rodada <= '0;
      else if (w_inc_rodada) r_rodada <= r_rodada + UM_A;
      if (w_clr_cont)        r_contagem <= '0;
      else if (w_inc_cont)   r_contagem <= r_contagem + UM_A;
      if (w_prox != r_estado) r_timer <= '0;
      else if (w_inc_timer)   r_timer <= r_timer + UM_T;
      // The delayed sample is the exact vector that raised the play pulse.
      if (w_limpa_jogada)    r_jogada <= '0;
      else if (w_captura)    r_jogada <= r_amostra_ant;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_amostra     <= '0;
      r_amostra_ant <= '0;
    end else begin
`ifdef MOSTRA_JOGADA_EN
      if (w_rearma) begin
        r_amostra     <= '0;
        r_amostra_ant <= '0;
      end else
`endif
      begin
        r_amostra     <= bus.chaves;
        r_amostra_ant <= r_amostra;
      end
    end
  end

  // Sequence memory survives reset so a game can be replayed without reloading.
  always_ff @(posedge clock) begin
    if (w_carga_ok) r_mem[bus.end_carga] <= bus.dado_carga;
  end

  always_comb begin
    bus.leds = '0;
    case (r_estado)
      ESPERA, REGISTRA, COMPARA, PROXIMA: bus.leds = r_jogada;
`ifdef MOSTRA_JOGADA_EN
      NOVA_RODADA: bus.leds = r_mem[r_rodada];
`endif
      default: bus.leds = '0;
    endcase
  end

  assign bus.acertou     = (r_estado == FIM_ACERTO);
  assign bus.errou       = (r_estado == FIM_ERRO);
  assign bus.timeout     = (r_estado == FIM_TIMEOUT);
  assign bus.pronto      = w_final;
  assign bus.db_estado   = r_estado;
  assign bus.db_rodada   = r_rodada;
  assign bus.db_contagem = r_contagem;
  assign bus.db_jogada   = r_jogada;
endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Directed bench for jogo_sequencia_param: full win, wrong play, timeout,
// late play, held switch, load lock-out and mid-game reset with memory retention.
module tb_jogo_sequencia_param;
  localparam int NC = 4;
  localparam int NJ = 16;
  localparam int TO = 3000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  jogo_sequencia_param_if #(.N_CHAVES(NC), .N_JOGADAS(NJ)) io ();

  jogo_sequencia_param #(
    .N_CHAVES(NC), .N_JOGADAS(NJ), .TIMEOUT_CICLOS(TO), .MOSTRA_CICLOS(500)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (io.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got time limit expired, expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [NC-1:0] seq [NJ] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0100, 4'b0010, 4'b0001, 4'b0001,
                              4'b0010, 4'b0010, 4'b0100, 4'b0100,
                              4'b1000, 4'b1000, 4'b0001, 4'b0100};
  logic [NC-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic play(input logic [NC-1:0] v);
    logic [NC-1:0] e;
    exp_q.push_back(v);
    io.chaves = v;
    tick(10);
    e = exp_q.pop_front();
    check_eq("db_jogada", 32'(io.db_jogada), 32'(e));
    io.chaves = '0;
    tick(10);
  endtask

  task automatic play_round(input int r);
    for (int i = 0; i <= r; i++) play(seq[i]);
  endtask

  task automatic start(input int n);
    io.iniciar = 1'b1;
    tick(n);
    io.iniciar = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_acertou"},  32'(io.acertou),     32'd0);
    check_eq({tag, "_errou"},    32'(io.errou),       32'd0);
    check_eq({tag, "_timeout"},  32'(io.timeout),     32'd0);
    check_eq({tag, "_pronto"},   32'(io.pronto),      32'd0);
    check_eq({tag, "_leds"},     32'(io.leds),        32'd0);
    check_eq({tag, "_estado"},   32'(io.db_estado),   32'd0);
    check_eq({tag, "_rodada"},   32'(io.db_rodada),   32'd0);
    check_eq({tag, "_contagem"}, 32'(io.db_contagem), 32'd0);
    check_eq({tag, "_jogada"},   32'(io.db_jogada),   32'd0);
  endtask

  task automatic check_win(input string tag);
    check_eq({tag, "_pronto"},   32'(io.pronto),      32'd1);
    check_eq({tag, "_acertou"},  32'(io.acertou),     32'd1);
    check_eq({tag, "_errou"},    32'(io.errou),       32'd0);
    check_eq({tag, "_timeout"},  32'(io.timeout),     32'd0);
    check_eq({tag, "_estado"},   32'(io.db_estado),   32'd7);
    check_eq({tag, "_rodada"},   32'(io.db_rodada),   32'd15);
    check_eq({tag, "_contagem"}, 32'(io.db_contagem), 32'd15);
    check_eq({tag, "_leds"},     32'(io.leds),        32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    io.iniciar    = 1'b0;
    io.chaves     = '0;
    io.carga      = 1'b0;
    io.end_carga  = '0;
    io.dado_carga = '0;
    tick(3);
    check_idle("reset");
    reset = 1'b0;
    tick(1);

    for (int i = 0; i < NJ; i++) begin
      io.carga      = 1'b1;
      io.end_carga  = 4'(i);
      io.dado_carga = seq[i];
      tick(1);
    end
    io.carga = 1'b0;

    // game 1: full correct game
    start(5);
    check_eq("start_estado", 32'(io.db_estado), 32'd3);
    for (int r = 0; r < NJ; r++) begin
      play_round(r);
      if (r < NJ - 1) check_eq("round_advance", 32'(io.db_rodada), 32'(r + 1));
    end
    check_win("win1");

    // game 2: wrong third play of round 2
    io.iniciar = 1'b1;
    tick(1);
    check_eq("restart_acertou", 32'(io.acertou), 32'd0);
    check_eq("restart_estado", 32'(io.db_estado), 32'd1);
    tick(4);
    io.iniciar = 1'b0;
    play_round(0);
    play_round(1);
    play(seq[0]);
    play(seq[1]);
    io.chaves = 4'b0001;
    tick(1);
    tick(2);
    check_eq("err_early_errou", 32'(io.errou), 32'd0);
    check_eq("err_early_estado", 32'(io.db_estado), 32'd5);
    tick(1);
    check_eq("err_errou", 32'(io.errou), 32'd1);
    check_eq("err_pronto", 32'(io.pronto), 32'd1);
    check_eq("err_acertou", 32'(io.acertou), 32'd0);
    check_eq("err_estado", 32'(io.db_estado), 32'd8);
    check_eq("err_contagem", 32'(io.db_contagem), 32'd2);
    check_eq("err_rodada", 32'(io.db_rodada), 32'd2);
    check_eq("err_jogada", 32'(io.db_jogada), 32'b0001);
    io.chaves = '0;
    tick(5);
    check_eq("err_held", 32'(io.errou), 32'd1);

    // timeout with no play
    io.iniciar = 1'b1;
    tick(1);
    io.iniciar = 1'b0;
    check_eq("to_clear_errou", 32'(io.errou), 32'd0);
    tick(2);
    check_eq("to_espera", 32'(io.db_estado), 32'd3);
    tick(TO - 1);
    check_eq("to_before", 32'(io.timeout), 32'd0);
    check_eq("to_before_estado", 32'(io.db_estado), 32'd3);
    tick(1);
    check_eq("to_timeout", 32'(io.timeout), 32'd1);
    check_eq("to_pronto", 32'(io.pronto), 32'd1);
    check_eq("to_estado", 32'(io.db_estado), 32'd9);

    // play at TO-2 clocks after ESPERA entry: no timeout
    io.iniciar = 1'b1;
    tick(1);
    io.iniciar = 1'b0;
    tick(2);
    tick(TO - 3);
    io.chaves = seq[0];
    tick(1);
    tick(2);
    check_eq("late_timeout", 32'(io.timeout), 32'd0);
    check_eq("late_estado", 32'(io.db_estado), 32'd5);
    tick(1);
    check_eq("late_nova", 32'(io.db_estado), 32'd2);
    check_eq("late_rodada", 32'(io.db_rodada), 32'd1);
    io.chaves = '0;
    tick(10);

    // held switch in round 1 counts once
    io.chaves = seq[0];
    tick(50);
    check_eq("hold_contagem", 32'(io.db_contagem), 32'd1);
    check_eq("hold_estado", 32'(io.db_estado), 32'd3);
    check_eq("hold_leds", 32'(io.leds), 32'b0001);
    check_eq("hold_errou", 32'(io.errou), 32'd0);
    io.chaves = '0;
    tick(10);
    play(seq[1]);
    check_eq("hold_rodada", 32'(io.db_rodada), 32'd2);
    check_eq("hold_cont0", 32'(io.db_contagem), 32'd0);

    // progress into round 5, try a load in ESPERA, then reset
    play_round(2);
    play_round(3);
    play_round(4);
    play(seq[0]);
    play(seq[1]);
    check_eq("mid_rodada", 32'(io.db_rodada), 32'd5);
    check_eq("mid_estado", 32'(io.db_estado), 32'd3);
    io.carga      = 1'b1;
    io.end_carga  = '0;
    io.dado_carga = 4'b1111;
    tick(1);
    io.carga = 1'b0;
    reset = 1'b1;
    #2;
    check_idle("reset_mid");
    tick(2);
    reset = 1'b0;
    tick(1);

    // game 3: replay proves memory (including mem[0]) is intact
    start(5);
    for (int r = 0; r < NJ; r++) play_round(r);
    check_win("win2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/jogo_sequencia_param.md
Name: jogo_sequencia_param

Overview:
Parametrised memory-sequence game core, successor to the fixed 4-switch/16-play experiment circuit. It stores a sequence of switch patterns, then plays progressive rounds: round r requires the player to repeat entries 0..r. It detects a play on the switch inputs and compares it with memory. It reports hit, miss or timeout. It sits between board I/O (switches, LEDs, 7-seg debug decoders) and the top-level wrapper.

Parameters:
N_CHAVES, 4, width of switch/LED vector (>=2)
N_JOGADAS, 16, sequence depth = number of rounds (>=2, power of 2 not required)
TIMEOUT_CICLOS, 3000, clocks allowed per play before timeout (3 s at 1 kHz)
MOSTRA_CICLOS, 500, clocks each new element is shown on leds (only with MOSTRA_JOGADA_EN)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears FSM and counters, NOT memory
iniciar  in  1  level; start / restart game
chaves  in  N_CHAVES  player switches; all-zero = idle
carga  in  1  memory write enable (accepted only in INICIAL or final states)
end_carga  in  A=$clog2(N_JOGADAS)  write address
dado_carga  in  N_CHAVES  write data
acertou  out  1  game won (held)
errou  out  1  wrong play (held)
timeout  out  1  play timeout (held)
pronto  out  1  game finished (held, with exactly one of the above)
leds  out  N_CHAVES  display vector
db_estado  out  4  FSM state code
db_rodada  out  A  current round index
db_contagem  out  A  current play index within round
db_jogada  out  N_CHAVES  last registered play

Behaviour:
- Reset: all outputs 0, state INICIAL, rodada=contagem=0, timeout counter 0. Memory contents retained.
- Play detection: chaves registered each clock; jogada pulse = (sample!=0) and (previous sample==0). Holding switches gives one play only; release to 0 re-arms.
- States (codes): INICIAL 0, PREPARA 1, NOVA_RODADA 2, ESPERA 3, REGISTRA 4, COMPARA 5, PROXIMA 6, FIM_ACERTO 7, FIM_ERRO 8, FIM_TIMEOUT 9.
- INICIAL --iniciar--> PREPARA: rodada=0, contagem=0, outputs cleared.
- PREPARA -> NOVA_RODADA -> ESPERA: contagem=0, timeout counter cleared.
- ESPERA: counter increments each clock. On jogada pulse -> REGISTRA. If counter reaches TIMEOUT_CICLOS-1 with no pulse -> FIM_TIMEOUT. A pulse on the same clock as expiry wins.
- REGISTRA: db_jogada <= sample. COMPARA: igual = (db_jogada == mem[contagem]), exact vector match.
- Mismatch -> FIM_ERRO. Match and contagem<rodada -> PROXIMA (contagem++, timer cleared) -> ESPERA. Match and contagem==rodada and rodada==N_JOGADAS-1 -> FIM_ACERTO. Otherwise rodada++ -> NOVA_RODADA.
- Latency: pulse sampled at edge T; REGISTRA at T+1; COMPARA at T+2; errou/acertou/next state visible after edge T+3.
- Final states: pronto=1 plus the matching flag, held. iniciar -> PREPARA, flags cleared the next clock. iniciar in any other non-INICIAL state is ignored.
- leds: shows db_jogada in ESPERA..PROXIMA, 0 elsewhere.
- Load: carga=1 in INICIAL/FIM_* writes mem[end_carga]<=dado_carga on the edge. Ignored in other states. An address >= N_JOGADAS is ignored.
- Reset mid-game: immediate return to INICIAL, outputs 0, memory intact.

Optional Feature:
MOSTRA_JOGADA_EN: when defined, NOVA_RODADA lasts MOSTRA_CICLOS clocks with leds=mem[rodada]. A jogada pulse during the show is discarded, and the pulse detector is re-armed on exit. When undefined, NOVA_RODADA lasts 1 clock and leds=0 there.

Test Plan:
Load 16 entries (0001,0010,0100,1000,0100,0010,0001,0001,0010,0010,0100,0100,1000,1000,0001,0100), iniciar 5 clocks, play rounds 0..15 correctly (10 clk on, 10 clk off) -> pronto=1, acertou=1 after 136 plays, db_rodada=15.
Same load, round 2 third play 0001 instead of 0100 -> errou=1, pronto=1, db_contagem=2, db_rodada=2, exactly 3 clocks after sampling.
iniciar, no play -> timeout=1, pronto=1 at TIMEOUT_CICLOS clocks after ESPERA entry. A play at TIMEOUT_CICLOS-2 clocks -> no timeout.
Hold chaves=0001 for 50 clocks in round 1 -> counts as one play only, db_contagem advances by 1.
reset pulse mid round 5 -> all outputs 0, state 0. Re-iniciar and replay -> memory unchanged, game wins.
carga during ESPERA with dado 1111 at addr 0 -> ignored, later mem[0] still 0001. With MOSTRA_JOGADA_EN, leds=mem[rodada] for MOSTRA_CICLOS in each NOVA_RODADA.
